// File: rtl/array_div_pkg.sv
// Shared types and constants for the array divider sequencer.
//   W         default operand/quotient word width
//   word_t    one operand or quotient word
//   div_seq_state_t  sequencer FSM states
//   QUOT_SAT  quotient substituted in every lane on a zero divisor
// The lane array type depends on the lane count, which is a module
// parameter, so it is declared inside the module that owns N.
package array_div_pkg;

  localparam int unsigned W = 36;

  typedef logic [W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } div_seq_state_t;

  localparam word_t QUOT_SAT = {32'hFFFF_FFFF, 4'h0};

endpackage

// File: rtl/array_div_seq.sv
// Sequencer for the shared N-lane fixed-point array divider.
// Accepts one request (divisor + N dividends) on start while ready, holds the
// registered operands on the divider inputs, enables the divider for exactly
// LATENCY cycles, captures the N quotients and presents them with valid until
// result_ack. A zero divisor bypasses the divider and returns QUOT_SAT lanes
// with div_by_zero set.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start / ready         request handshake (ready only in IDLE)
//   divisor_in            divisor, sampled at accept
//   dividends_in          N dividends, sampled at accept
//   div_en                divider clock enable
//   div_divisor           registered divisor to the divider
//   div_dividends         registered dividends to the divider
//   div_quotients         divider quotient outputs
//   valid / result_ack    result handshake (valid only in DONE)
//   quotients_out         captured quotients, stable while valid
//   div_by_zero           qualifies quotients_out
module array_div_seq #(
  parameter int unsigned N       = 6,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned W       = 36
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                ready,
  input  logic [W-1:0]        divisor_in,
  input  logic [N-1:0][W-1:0] dividends_in,
  output logic                div_en,
  output logic [W-1:0]        div_divisor,
  output logic [N-1:0][W-1:0] div_dividends,
  input  logic [N-1:0][W-1:0] div_quotients,
  output logic                valid,
  input  logic                result_ack,
  output logic [N-1:0][W-1:0] quotients_out,
  output logic                div_by_zero
);

  import array_div_pkg::*;

  typedef logic [N-1:0][W-1:0] lanes_t;

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [W-1:0]  SAT_W    = W'(QUOT_SAT);

  div_seq_state_t state, state_d;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           divisor_zero;

  assign divisor_zero = (divisor_in == '0);
  assign accept       = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      div_divisor   <= '0;
      div_dividends <= '0;
      quotients_out <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (start) begin
            div_divisor   <= divisor_in;
            div_dividends <= dividends_in;
            if (divisor_zero) begin
              quotients_out <= lanes_t'({N{SAT_W}});
              div_by_zero   <= 1'b1;
            end else begin
              cnt <= CNT_LOAD;
            end
          end
        end
        RUN: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        CAPT: begin
          quotients_out <= div_quotients;
          div_by_zero   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    ready   = 1'b0;
    div_en  = 1'b0;
    valid   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_d = divisor_zero ? DONE : RUN;
      end
      RUN: begin
        div_en = 1'b1;
        if (cnt == '0) state_d = CAPT;
      end
      CAPT: state_d = DONE;
      DONE: begin
        valid = 1'b1;
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_array_div_seq.sv
// Directed self-checking bench for array_div_seq with a behavioural
// LATENCY-stage clock-enabled divider model.
module tb_array_div_seq;

  localparam int unsigned N       = 6;
  localparam int unsigned LATENCY = 8;
  localparam int unsigned W       = 36;

  typedef logic [N-1:0][W-1:0] lanes_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         ready;
  logic [W-1:0] divisor_in;
  lanes_t       dividends_in;
  logic         div_en;
  logic [W-1:0] div_divisor;
  lanes_t       div_dividends;
  lanes_t       div_quotients;
  logic         valid;
  logic         result_ack;
  lanes_t       quotients_out;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  array_div_seq #(.N(N), .LATENCY(LATENCY), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .divisor_in(divisor_in), .dividends_in(dividends_in),
    .div_en(div_en), .div_divisor(div_divisor), .div_dividends(div_dividends),
    .div_quotients(div_quotients), .valid(valid), .result_ack(result_ack),
    .quotients_out(quotients_out), .div_by_zero(div_by_zero)
  );

  // Behavioural divider: q = {dividend,12'b0}/divisor, lane = {q[31:0],4'b0}
  function automatic lanes_t divide(input lanes_t dvd, input logic [W-1:0] dvs);
    lanes_t r;
    logic [47:0] num, q;
    for (int i = 0; i < N; i++) begin
      num = {dvd[i], 12'b0};
      q   = (dvs == '0) ? 48'd0 : num / {12'b0, dvs};
      r[i] = {q[31:0], 4'b0};
    end
    return r;
  endfunction

  lanes_t pipe [LATENCY];
  always @(posedge clk) begin
    if (div_en) begin
      pipe[0] <= divide(div_dividends, div_divisor);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign div_quotients = pipe[LATENCY-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [W-1:0] dvs, input lanes_t dvd);
    divisor_in   = dvs;
    dividends_in = dvd;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Edges from the accept edge until valid is seen, counting div_en cycles.
  task automatic wait_valid(output int en_cnt, output int lat);
    en_cnt = 0;
    lat    = 0;
    while (!valid && lat < 100) begin
      if (div_en) en_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic check_lanes(input string tag, input lanes_t exp);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_lane%0d", tag, i), 64'(quotients_out[i]), 64'(exp[i]));
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack_valid_low", 64'(valid), 64'd0);
    check("ack_ready_high", 64'(ready), 64'd1);
  endtask

  lanes_t ones, mixed, mixed_exp, e8000, sat, fives, eights, e20000, saved;
  int en_cnt, lat;

  initial begin
    for (int i = 0; i < N; i++) begin
      ones[i]      = 36'd1;
      mixed[i]     = 36'(3 * i);
      mixed_exp[i] = 36'(32'h0001_0000 * i);
      e8000[i]     = 36'h0_0000_8000;
      sat[i]       = 36'hF_FFFF_FFF0;
      fives[i]     = 36'd5;
      eights[i]    = 36'd8;
      e20000[i]    = 36'h0_0002_0000;
    end
    reset = 1'b1; start = 1'b0; result_ack = 1'b0;
    divisor_in = '0; dividends_in = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_divisor", 64'(div_divisor), 64'd0);
    check("rst_quot0", 64'(quotients_out[0]), 64'd0);

    // 1. Basic run
    accept_req(36'd2, ones);
    check("t1_ready_low", 64'(ready), 64'd0);
    wait_valid(en_cnt, lat);
    check("t1_en_cycles", 64'(en_cnt), 64'd8);
    check("t1_latency", 64'(lat), 64'd9);
    check_lanes("t1", e8000);
    check("t1_dbz", 64'(div_by_zero), 64'd0);
    do_ack();

    // 2. Mixed lanes
    accept_req(36'd3, mixed);
    wait_valid(en_cnt, lat);
    check("t2_latency", 64'(lat), 64'd9);
    check_lanes("t2", mixed_exp);
    check("t2_lane1", 64'(quotients_out[1]), 64'h0_0001_0000);
    do_ack();

    // 3. Zero divisor
    accept_req(36'd0, mixed);
    wait_valid(en_cnt, lat);
    check("t3_en_cycles", 64'(en_cnt), 64'd0);
    check("t3_latency", 64'(lat), 64'd0);
    check("t3_div_en", 64'(div_en), 64'd0);
    check_lanes("t3", sat);
    check("t3_dbz", 64'(div_by_zero), 64'd1);
    do_ack();

    // 4. Back-pressure
    accept_req(36'd2, ones);
    wait_valid(en_cnt, lat);
    check("t4_latency", 64'(lat), 64'd9);
    saved = quotients_out;
    for (int c = 0; c < 20; c++) begin
      start      = c[0];
      divisor_in = 36'd9;
      tick();
      check("t4_ready_low", 64'(ready), 64'd0);
      check("t4_valid_held", 64'(valid), 64'd1);
      check("t4_quot_stable", 64'(quotients_out[c % N]), 64'(saved[c % N]));
    end
    start = 1'b0;
    check("t4_divisor_held", 64'(div_divisor), 64'd2);
    do_ack();
    accept_req(36'd4, eights);
    check("t4_new_accept", 64'(div_divisor), 64'd4);
    wait_valid(en_cnt, lat);
    check_lanes("t4new", e20000);
    do_ack();

    // 5. Reset on the 4th RUN cycle
    accept_req(36'd7, fives);
    tick(); tick(); tick();
    check("t5_in_run", 64'(div_en), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_ready", 64'(ready), 64'd1);
    check("t5_div_en", 64'(div_en), 64'd0);
    check("t5_valid", 64'(valid), 64'd0);
    check("t5_divisor", 64'(div_divisor), 64'd0);
    check("t5_dividend0", 64'(div_dividends[0]), 64'd0);
    check("t5_quot0", 64'(quotients_out[0]), 64'd0);
    accept_req(36'd2, ones);
    wait_valid(en_cnt, lat);
    check("t5_en_cycles", 64'(en_cnt), 64'd8);
    check_lanes("t5", e8000);
    do_ack();

    // 6. Back-to-back with ack held and start held
    result_ack   = 1'b1;
    divisor_in   = 36'd3;
    dividends_in = mixed;
    start        = 1'b1;
    tick();
    divisor_in   = 36'd2;
    dividends_in = ones;
    wait_valid(en_cnt, lat);
    check("t6a_latency", 64'(lat), 64'd9);
    check_lanes("t6a", mixed_exp);
    tick();
    check("t6_gap_ready", 64'(ready), 64'd1);
    check("t6_gap_valid", 64'(valid), 64'd0);
    tick();
    start      = 1'b0;
    result_ack = 1'b0;
    check("t6b_accepted", 64'(ready), 64'd0);
    check("t6b_divisor", 64'(div_divisor), 64'd2);
    wait_valid(en_cnt, lat);
    check("t6b_latency", 64'(lat), 64'd9);
    check_lanes("t6b", e8000);
    check("t6b_dbz", 64'(div_by_zero), 64'd0);
    do_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
